// File: rtl/bist_pkg.sv
// bist_pkg: shared BIST definitions for the controller, MISR and system top.
// Holds the controller state encoding, the CUT latency ceiling and the
// default signature width / golden signature.
package bist_pkg;

   localparam int unsigned MAX_CUT_LATENCY = 7;
   localparam int unsigned LAT_CNT_W       = $clog2(MAX_CUT_LATENCY + 1);

   localparam int unsigned            DEF_SIG_W      = 8;
   localparam logic [DEF_SIG_W-1:0]   DEF_GOLDEN_SIG = 8'hA5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEED    = 3'd1,
      RUN     = 3'd2,
      FLUSH   = 3'd3,
      COMPARE = 3'd4,
      DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/bist_delay_line.sv
// bist_delay_line: 1-bit shift register that delays a strobe by DEPTH cycles.
// DEPTH = 0 is a straight wire.
// Ports:
//   clk   in  1  clock, rising edge
//   clr   in  1  synchronous clear of all stages
//   din   in  1  strobe in
//   dout  out 1  strobe delayed by DEPTH cycles
module bist_delay_line #(
   parameter int unsigned DEPTH = 1
) (
   input  logic clk,
   input  logic clr,
   input  logic din,
   output logic dout
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign dout = din;
      end else begin : g_shift
         logic [DEPTH-1:0] sr;

         always_ff @(posedge clk) begin
            if (clr) sr <= '0;
            else     sr <= (sr << 1) | DEPTH'(din);
         end

         assign dout = sr[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/bist_controller.sv
// bist_controller: sequencing FSM for the BIST of a multiplier CUT.
// Seeds the LFSR and MISR, runs NUM_PATTERNS patterns, lets the CUT pipeline
// drain, then compares the MISR signature with GOLDEN_SIG.
// Optional macro BIST_SIG_CAPTURE_EN: keep the final signature in sig_capture
// for diagnosis; otherwise sig_capture is tied to 0.
// Ports:
//   clk          in  1      clock, rising edge
//   rst          in  1      synchronous active-high reset
//   enable       in  1      level start/run request
//   misr_sig     in  SIG_W  current MISR signature
//   tpg_load     out 1      load LFSR seed
//   tpg_en       out 1      advance LFSR
//   misr_clr     out 1      clear MISR to its seed
//   misr_en      out 1      MISR compacts CUT output
//   busy         out 1      test in progress
//   done         out 1      test finished, result valid
//   pass         out 1      signature matched GOLDEN_SIG
//   sig_capture  out SIG_W  captured final signature
module bist_controller
   import bist_pkg::*;
#(
   parameter int unsigned      NUM_PATTERNS = 15,
   parameter int unsigned      SIG_W        = DEF_SIG_W,
   parameter logic [SIG_W-1:0] GOLDEN_SIG   = SIG_W'(DEF_GOLDEN_SIG),
   parameter int unsigned      CUT_LATENCY  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [SIG_W-1:0] misr_sig,
   output logic             tpg_load,
   output logic             tpg_en,
   output logic             misr_clr,
   output logic             misr_en,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] sig_capture
);

   localparam int unsigned          CNT_W    = $clog2(NUM_PATTERNS + 1);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(NUM_PATTERNS - 1);
   localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(CUT_LATENCY - 1);

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [LAT_CNT_W-1:0] lat_cnt, lat_nxt;
   logic                 abort_c;
   logic                 dl_clr;

   // Next state, counters and strobes decoded from the registered state.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lat_nxt   = lat_cnt;
      abort_c   = 1'b0;
      tpg_load  = 1'b0;
      misr_clr  = 1'b0;
      tpg_en    = 1'b0;
      busy      = 1'b0;

      case (state)
         IDLE: begin
            if (enable) state_nxt = SEED;
         end
         SEED: begin
            tpg_load  = 1'b1;
            misr_clr  = 1'b1;
            busy      = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            tpg_en = 1'b1;
            busy   = 1'b1;
            if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = (CUT_LATENCY == 0) ? COMPARE : FLUSH;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         FLUSH: begin
            busy = 1'b1;
            if (lat_cnt == LAT_LAST) begin
               lat_nxt   = '0;
               state_nxt = COMPARE;
            end else begin
               lat_nxt = lat_cnt + LAT_CNT_W'(1);
            end
         end
         COMPARE: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            if (!enable) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Dropping enable mid-test abandons the run without a verdict.
      if (busy && !enable) begin
         abort_c   = 1'b1;
         state_nxt = IDLE;
         cnt_nxt   = '0;
         lat_nxt   = '0;
      end
   end

   // State register plus the registered verdict flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         lat_cnt <= '0;
         done    <= 1'b0;
         pass    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         lat_cnt <= lat_nxt;
         // Gated by enable so done falls together with the return to IDLE.
         done    <= (state == DONE) && enable;
         if (abort_c || (state == SEED))
            pass <= 1'b0;
         else if (state == COMPARE)
            pass <= (misr_sig == GOLDEN_SIG);
      end
   end

   // Align MISR compaction with the CUT pipeline; aborts discard pending strobes.
   assign dl_clr = rst | abort_c;

   bist_delay_line #(
      .DEPTH (CUT_LATENCY)
   ) u_delay (
      .clk  (clk),
      .clr  (dl_clr),
      .din  (tpg_en),
      .dout (misr_en)
   );

`ifdef BIST_SIG_CAPTURE_EN
   // Final signature kept until the next completed comparison.
   always_ff @(posedge clk) begin
      if (rst)
         sig_capture <= '0;
      else if ((state == COMPARE) && !abort_c)
         sig_capture <= misr_sig;
   end
`else
   assign sig_capture = '0;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: directed-plus-random bench for bist_controller.
// Wraps the default DUT with an LFSR / 4x4 multiplier / MISR system model and
// checks the verdict against a pattern-level signature model. A second DUT
// (NUM_PATTERNS = 1, CUT_LATENCY = 0) checks the minimal configuration.
module tb_bist_controller;

   localparam int          NP        = 15;
   localparam int          LAT       = 1;
   localparam int          EXP_DONE  = NP + LAT + 3;
   localparam int          EXP_DONE2 = 1 + 0 + 3;
   localparam logic [7:0]  GOLD      = 8'hA5;
   localparam logic [7:0]  LFSR_SEED = 8'h01;

   logic       clk = 1'b0;
   logic       rst, enable, enable2;
   logic [7:0] misr_sig, misr_sig2, sig_capture, sig_capture2;
   logic       tpg_load, tpg_en, misr_clr, misr_en, busy, done, pass;
   logic       tpg_load2, tpg_en2, misr_clr2, misr_en2, busy2, done2, pass2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bist_controller u_dut (
      .clk (clk), .rst (rst), .enable (enable), .misr_sig (misr_sig),
      .tpg_load (tpg_load), .tpg_en (tpg_en), .misr_clr (misr_clr),
      .misr_en (misr_en), .busy (busy), .done (done), .pass (pass),
      .sig_capture (sig_capture)
   );

   bist_controller #(.NUM_PATTERNS (1), .CUT_LATENCY (0)) u_dut2 (
      .clk (clk), .rst (rst), .enable (enable2), .misr_sig (misr_sig2),
      .tpg_load (tpg_load2), .tpg_en (tpg_en2), .misr_clr (misr_clr2),
      .misr_en (misr_en2), .busy (busy2), .done (done2), .pass (pass2),
      .sig_capture (sig_capture2)
   );

   // ---------------- system model around the default DUT ----------------
   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [7:0] d);
      return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ d;
   endfunction

   function automatic logic [7:0] cut(input logic [7:0] l, input logic stk);
      return (8'(l[7:4]) * 8'(l[3:0])) | {7'b0, stk};
   endfunction

   // Pattern-level signature: NP patterns from the seed, each product folded once.
   function automatic logic [7:0] ref_sig(input logic [7:0] seed, input logic stk);
      logic [7:0] l, m;
      l = LFSR_SEED;
      m = seed;
      for (int i = 0; i < NP; i++) begin
         m = misr_step(m, cut(l, stk));
         l = lfsr_next(l);
      end
      return m;
   endfunction

   function automatic logic [7:0] exp_cap(input logic [7:0] s);
`ifdef BIST_SIG_CAPTURE_EN
      return s;
`else
      return 8'h00 & s;
`endif
   endfunction

   logic [7:0] lfsr, prod_q, misr, mseed;
   logic       stuck;

   assign misr_sig = misr;

   always @(posedge clk) begin
      if (rst) begin
         lfsr   <= '0;
         prod_q <= '0;
         misr   <= '0;
      end else begin
         if (tpg_load)    lfsr <= LFSR_SEED;
         else if (tpg_en) lfsr <= lfsr_next(lfsr);
         prod_q <= cut(lfsr, stuck);
         if (misr_clr)     misr <= mseed;
         else if (misr_en) misr <= misr_step(misr, prod_q);
      end
   end

   // ---------------- strobe monitor (mid-cycle sampling) ----------------
   int   n_tpg = 0, n_misr = 0, n_load = 0, n_lag = 0;
   int   n_tpg2 = 0, n_misr2 = 0, n_coin2 = 0;
   logic tpg_en_d = 1'b0;

   always @(negedge clk) begin
      if (tpg_en)   n_tpg++;
      if (misr_en)  n_misr++;
      if (tpg_load) n_load++;
      if (misr_en !== tpg_en_d) n_lag++;
      tpg_en_d <= tpg_en;
      if (tpg_en2)  n_tpg2++;
      if (misr_en2) n_misr2++;
      if (misr_en2 !== tpg_en2) n_coin2++;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise enable; edge 0 is the first edge that samples it.
   task automatic run_dut1(input string tag);
      int edge_n;
      edge_n = -1;
      enable = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edge_n = k;
            break;
         end
      end
      chk({tag, "_done_edge"}, edge_n, EXP_DONE);
   endtask

   task automatic drop_en1();
      enable = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int         s_t, s_m, s_l, s_ld, k, e2;
      logic       found;
      logic [7:0] sig_f, v;

      rst       = 1'b1;
      enable    = 1'b0;
      enable2   = 1'b0;
      stuck     = 1'b0;
      misr_sig2 = '0;
      mseed     = '0;
      found     = 1'b0;

      // MISR seed for which the fault-free system signature is the golden value.
      for (int s = 0; s < 256; s++) begin
         if (!found && ref_sig(8'(s), 1'b0) == GOLD) begin
            mseed = 8'(s);
            found = 1'b1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs",  {busy, done, pass, tpg_load, tpg_en, misr_clr, misr_en}, 0);
      chk("rst_sig",   sig_capture, 0);
      chk("rst_outs2", {busy2, done2, pass2, tpg_load2, tpg_en2, misr_clr2, misr_en2}, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Fault-free run with default parameters.
      s_t = n_tpg; s_m = n_misr; s_l = n_lag;
      run_dut1("ok");
      chk("ok_pass",  pass, 1);
      chk("ok_busy",  busy, 0);
      chk("ok_tpg",   n_tpg - s_t, NP);
      chk("ok_misr",  n_misr - s_m, NP);
      chk("ok_lag",   n_lag - s_l, 0);
      chk("ok_sig",   sig_capture, exp_cap(ref_sig(mseed, 1'b0)));

      // Held enable after DONE must not restart.
      s_ld = n_load;
      repeat (20) @(posedge clk);
      #1;
      chk("hold_load", n_load - s_ld, 0);
      chk("hold_done", done, 1);
      chk("hold_busy", busy, 0);
      drop_en1();
      chk("idle_done", done, 0);
      chk("idle_pass", pass, 1);

      // Stuck-at-1 on product bit 0.
      stuck = 1'b1;
      sig_f = ref_sig(mseed, 1'b1);
      run_dut1("sa");
      chk("sa_pass", pass, 32'(sig_f == GOLD));
      chk("sa_sig",  sig_capture, exp_cap(sig_f));
      drop_en1();
      stuck = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Abort at a random RUN count.
      k   = int'($urandom_range(NP - 1, 0));
      s_t = n_tpg;
      enable = 1'b1;
      @(posedge clk);
      repeat (1 + k) @(posedge clk);
      #1;
      enable = 1'b0;
      @(posedge clk);
      #1;
      chk("ab_outs", {busy, done, pass, tpg_en, misr_en, tpg_load}, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("ab_tpg", n_tpg - s_t, k + 1);
      run_dut1("re");
      chk("re_pass", pass, 1);
      drop_en1();

      // Reset pulse during FLUSH.
      enable = 1'b1;
      @(posedge clk);
      repeat (NP + 1) @(posedge clk);
      #1;
      chk("fl_misr_en", {busy, tpg_en, misr_en}, 3'b101);
      rst    = 1'b1;
      enable = 1'b0;
      @(posedge clk);
      #1;
      chk("rf_outs", {busy, done, pass, tpg_load, tpg_en, misr_clr, misr_en}, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rf_pass", pass, 0);
      run_dut1("ar");
      chk("ar_pass", pass, 1);
      drop_en1();

      // Minimal configuration: one pattern, no CUT latency.
      for (int it = 0; it < 4; it++) begin
         v = (it == 0) ? GOLD : 8'($urandom);
         misr_sig2 = v;
         s_t = n_tpg2; s_m = n_misr2; s_l = n_coin2;
         e2 = -1;
         enable2 = 1'b1;
         @(posedge clk);
         for (int j = 1; j <= 50; j++) begin
            @(posedge clk);
            #1;
            if (done2) begin
               e2 = j;
               break;
            end
         end
         chk("m_done_edge", e2, EXP_DONE2);
         chk("m_pass",  pass2, 32'(v == GOLD));
         chk("m_pulses", {8'(n_tpg2 - s_t), 8'(n_misr2 - s_m), 8'(n_coin2 - s_l)}, 24'h010100);
         chk("m_sig",   sig_capture2, exp_cap(v));
         enable2 = 1'b0;
         @(posedge clk);
         #1;
         chk("m_idle",  {done2, busy2}, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
